// File: rtl/turbo_deframer.sv
// turbo_deframer
//   Captures one turbo-encoder frame (length+1 payload triples followed by
//   TAIL_LEN tail triples) into a local buffer. The frame is then held for a
//   downstream decoder until that decoder acknowledges it.
//
//   Parameters
//     MAX_LEN   payload buffer depth in triples (addresses 0..MAX_LEN-1),
//               must not exceed 512 (9-bit address ports)
//     TAIL_LEN  number of tail triples following the payload
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     length                payload length minus one, sampled at frame start
//     in_valid              encoder triple valid
//     sys/par1/par2_bit     systematic and parity bits of the current triple
//     rd_addr / rd_data     decoder read port, {sys,par1,par2}, 1-cycle latency
//     tail_data             captured tail triples, entry 0 in the LSBs
//     frame_len             latched (clamped) length of the held frame
//     frame_ready           a complete frame is held
//     frame_ack             decoder releases the held frame
//     busy                  frame capture in progress
//     frame_err             sticky error flag
//
//   Build option
//     DEFRAMER_GAP_CHECK_EN  when defined, a gap in in_valid during capture
//                            flags frame_err and drops the frame.
module turbo_deframer #(
  parameter int unsigned MAX_LEN  = 512,
  parameter int unsigned TAIL_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            length,
  input  logic                  in_valid,
  input  logic                  sys_bit,
  input  logic                  par1_bit,
  input  logic                  par2_bit,
  input  logic [8:0]            rd_addr,
  output logic [2:0]            rd_data,
  output logic [3*TAIL_LEN-1:0] tail_data,
  output logic [8:0]            frame_len,
  output logic                  frame_ready,
  input  logic                  frame_ack,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, HOLD} state_t;

  state_t                state_q, state_d;
  logic [8:0]            counter_q, counter_d;
  logic [8:0]            frame_len_q, frame_len_d;
  logic [3*TAIL_LEN-1:0] tail_q, tail_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [2:0]            rd_data_q, rd_data_d;

  logic [2:0]            mem_q [MAX_LEN];
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [2:0]            triple;
  logic                  err_set;
  logic [8:0]            len_eff;

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    frame_len_d = frame_len_q;
    tail_d      = tail_q;
    ready_d     = ready_q;
    wr_en       = 1'b0;
    wr_addr     = counter_q[AW-1:0];
    triple      = {sys_bit, par1_bit, par2_bit};
    err_set     = 1'b0;
    len_eff     = length;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          if (32'(length) >= MAX_LEN) begin
            len_eff = 9'(MAX_LEN - 1);
            err_set = 1'b1;
          end
          frame_len_d = len_eff;
          // A single-triple frame has already written its only entry.
          if (len_eff == '0) begin
            state_d   = TAIL;
            counter_d = '0;
          end else begin
            state_d   = PAYLOAD;
            counter_d = 9'd1;
          end
        end
      end

      PAYLOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (counter_q == frame_len_q) begin
            state_d   = TAIL;
            counter_d = '0;
          end else begin
            counter_d = counter_q + 9'd1;
          end
        end
`ifdef DEFRAMER_GAP_CHECK_EN
        else begin
          err_set   = 1'b1;
          state_d   = IDLE;
          counter_d = '0;
        end
`endif
      end

      TAIL: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < TAIL_LEN; i++) begin
            if (counter_q == 9'(i)) tail_d[3*i +: 3] = triple;
          end
          if (counter_q == 9'(TAIL_LEN - 1)) begin
            state_d   = HOLD;
            counter_d = '0;
            ready_d   = 1'b1;
          end else begin
            counter_d = counter_q + 9'd1;
          end
        end
`ifdef DEFRAMER_GAP_CHECK_EN
        else begin
          err_set   = 1'b1;
          state_d   = IDLE;
          counter_d = '0;
        end
`endif
      end

      HOLD: begin
        // Input during hold is dropped; ack still releases the frame.
        if (in_valid) err_set = 1'b1;
        if (frame_ack) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        counter_d = '0;
        ready_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == PAYLOAD) || (state_d == TAIL);

    // A new error in the same cycle as an ack must survive the ack.
    if (err_set)        err_d = 1'b1;
    else if (frame_ack) err_d = 1'b0;
    else                err_d = err_q;

    rd_data_d = '0;
    if (32'(rd_addr) < MAX_LEN) rd_data_d = mem_q[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      frame_len_q <= '0;
      tail_q      <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      frame_len_q <= frame_len_d;
      tail_q      <= tail_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Payload buffer: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_addr] <= triple;
  end

  assign rd_data     = rd_data_q;
  assign tail_data   = tail_q;
  assign frame_len   = frame_len_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_turbo_deframer.sv
module tb_turbo_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  length;
  logic        in_valid;
  logic        sys_bit, par1_bit, par2_bit;
  logic [8:0]  rd_addr;
  logic [2:0]  rd_data;
  logic [11:0] tail_data;
  logic [8:0]  frame_len;
  logic        frame_ready;
  logic        frame_ack;
  logic        busy;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  turbo_deframer #(.MAX_LEN(256), .TAIL_LEN(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .length      (length),
    .in_valid    (in_valid),
    .sys_bit     (sys_bit),
    .par1_bit    (par1_bit),
    .par2_bit    (par2_bit),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tail_data   (tail_data),
    .frame_len   (frame_len),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  function automatic logic [2:0] pay(int i, int s);
    return 3'(i * 5 + s * 3 + (i >> 3));
  endfunction

  function automatic logic [2:0] tl(int t, int s);
    return 3'(7 - t) ^ 3'(s);
  endfunction

  function automatic logic [11:0] tail_exp(int s);
    logic [11:0] te;
    te = '0;
    for (int t = 0; t < 4; t++) te[3*t +: 3] = tl(t, s);
    return te;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given input; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [2:0] t);
    in_valid = v;
    {sys_bit, par1_bit, par2_bit} = t;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle();
    frame_ack = 1'b1;
    cyc(1'b0, 3'd0);
    frame_ack = 1'b0;
  endtask

  task automatic rd(input int a, input logic [2:0] exp, input string tag);
    rd_addr = 9'(a);
    cyc(1'b0, 3'd0);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic send_payload(input int first, input int last, input int seed);
    for (int i = first; i <= last; i++) cyc(1'b1, pay(i, seed));
  endtask

  task automatic send_tail(input int seed);
    for (int t = 0; t < 4; t++) begin
      if (t == 3) chk("ready_before_last_tail", 32'(frame_ready), 32'd0);
      cyc(1'b1, tl(t, seed));
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input int len, input int seed, input logic err_exp, input string tag);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_len"}, 32'(frame_len), 32'(len));
    chk({tag, "_err"}, 32'(frame_err), 32'(err_exp));
    chk({tag, "_tail"}, 32'(tail_data), 32'(tail_exp(seed)));
    if (len <= 15) begin
      for (int i = 0; i <= len; i++) rd(i, pay(i, seed), $sformatf("%s_rd%0d", tag, i));
    end else begin
      rd(0, pay(0, seed), {tag, "_rd_first"});
      rd(len / 2, pay(len / 2, seed), {tag, "_rd_mid"});
      rd(len, pay(len, seed), {tag, "_rd_last"});
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_len"}, 32'(frame_len), 32'd0);
    chk({tag, "_tail"}, 32'(tail_data), 32'd0);
    chk({tag, "_rd"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    reset = 1'b1; length = '0; in_valid = 1'b0; frame_ack = 1'b0;
    sys_bit = 1'b0; par1_bit = 1'b0; par2_bit = 1'b0; rd_addr = '0;
    cyc(1'b0, 3'd0);
    cyc(1'b0, 3'd0);
    check_reset_values("reset");
    reset = 1'b0;
    cyc(1'b0, 3'd0);

    // Nominal 8-triple frame.
    length = 9'd7;
    cyc(1'b1, pay(0, 1));
    chk("f7_busy_start", 32'(busy), 32'd1);
    length = 9'd3; // must be ignored mid-frame
    send_payload(1, 7, 1);
    chk("f7_busy_tail", 32'(busy), 32'd1);
    send_tail(1);
    check_frame(7, 1, 1'b0, "f7");
    rd(300, 3'd0, "rd_out_of_range");
    ack_cycle();
    chk("f7_ack_ready", 32'(frame_ready), 32'd0);

    // Gap after payload index 1 of a 4-triple frame.
    length = 9'd3;
    send_payload(0, 1, 2);
`ifdef DEFRAMER_GAP_CHECK_EN
    cyc(1'b0, 3'd0);
    chk("gap_err", 32'(frame_err), 32'd1);
    chk("gap_busy", 32'(busy), 32'd0);
    chk("gap_ready", 32'(frame_ready), 32'd0);
    cyc(1'b0, 3'd0);
    chk("gap_ready2", 32'(frame_ready), 32'd0);
    ack_cycle();
    chk("gap_err_cleared", 32'(frame_err), 32'd0);
`else
    cyc(1'b0, 3'd0);
    cyc(1'b0, 3'd0);
    chk("gap_busy_held", 32'(busy), 32'd1);
    chk("gap_no_err", 32'(frame_err), 32'd0);
    send_payload(2, 3, 2);
    send_tail(2);
    check_frame(3, 2, 1'b0, "gap");
    ack_cycle();
`endif

    // Single-triple frame, then activity while held.
    length = 9'd0;
    send_payload(0, 0, 3);
    chk("f0_busy", 32'(busy), 32'd1);
    send_tail(3);
    check_frame(0, 3, 1'b0, "f0");
    length = 9'd5;
    cyc(1'b1, 3'b101);
    chk("hold_in_err", 32'(frame_err), 32'd1);
    chk("hold_in_ready", 32'(frame_ready), 32'd1);
    chk("hold_in_len", 32'(frame_len), 32'd0);
    chk("hold_in_tail", 32'(tail_data), 32'(tail_exp(3)));
    rd(0, pay(0, 3), "hold_in_rd0");
    ack_cycle();
    chk("hold_ack_ready", 32'(frame_ready), 32'd0);
    chk("hold_ack_err", 32'(frame_err), 32'd0);
    chk("hold_ack_busy", 32'(busy), 32'd0);

    // Ack and input in the same held cycle: ack wins, input flags an error.
    length = 9'd1;
    send_payload(0, 1, 4);
    send_tail(4);
    check_frame(1, 4, 1'b0, "f1");
    frame_ack = 1'b1;
    cyc(1'b1, 3'b011);
    frame_ack = 1'b0;
    chk("ackvalid_ready", 32'(frame_ready), 32'd0);
    chk("ackvalid_busy", 32'(busy), 32'd0);
    chk("ackvalid_err", 32'(frame_err), 32'd1);
    cyc(1'b0, 3'd0);
    chk("ackvalid_idle_busy", 32'(busy), 32'd0);
    chk("ackvalid_err_sticky", 32'(frame_err), 32'd1);
    ack_cycle();
    chk("idle_ack_clears_err", 32'(frame_err), 32'd0);

    // Reset in the middle of a frame, with input valid that same cycle.
    length = 9'd10;
    send_payload(0, 4, 5);
    reset = 1'b1;
    cyc(1'b1, pay(5, 5));
    reset = 1'b0;
    check_reset_values("midreset");
    length = 9'd2;
    send_payload(0, 2, 6);
    send_tail(6);
    check_frame(2, 6, 1'b0, "after_reset");
    ack_cycle();

    // Oversized length is clamped to the buffer depth.
    chk("clamp_pre_err", 32'(frame_err), 32'd0);
    length = 9'd511;
    send_payload(0, 0, 7);
    chk("clamp_err", 32'(frame_err), 32'd1);
    chk("clamp_len", 32'(frame_len), 32'd255);
    send_payload(1, 254, 7);
    chk("clamp_busy_before_last", 32'(busy), 32'd1);
    send_payload(255, 255, 7);
    chk("clamp_busy_in_tail", 32'(busy), 32'd1);
    send_tail(7);
    check_frame(255, 7, 1'b1, "clamp");
    rd(256, 3'd0, "clamp_rd256");
    ack_cycle();
    chk("clamp_ack_err", 32'(frame_err), 32'd0);
    chk("clamp_ack_ready", 32'(frame_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
